// File: rtl/cavlc_enc_seq_if.sv
// CAVLC encoder sequencer bus.
// Carries the block-descriptor input handshake (in_*), the header fields of
// the active block (hdr_*), the per-element stream (elem_*), the output
// handshake towards the bitstream stage (out_valid/out_ready) and the sticky
// count-clip flag (cnt_err).
//   master : the side that produces descriptors and consumes the results
//   slave  : the sequencer itself
interface cavlc_enc_seq_if #(
  parameter int MAX_COEFF = 16,
  parameter int LVL_W     = 8,
  parameter int RB_W      = 5,
  parameter int CW        = 5
);
  logic                       in_valid;
  logic                       in_ready;
  logic [1:0]                 in_nc_mode;
  logic [9:0]                 in_topleft_x;
  logic [9:0]                 in_topleft_y;
  logic [1:0]                 in_t1_cnt;
  logic [2:0]                 in_t1_flag;
  logic [CW-1:0]              in_total_coeff;
  logic [CW-1:0]              in_total_zero;
  logic [CW-1:0]              in_level_cnt;
  logic [CW-1:0]              in_run_cnt;
  logic [MAX_COEFF*LVL_W-1:0] in_level_list;
  logic [MAX_COEFF*RB_W-1:0]  in_run_list;

  logic [1:0]                 hdr_nc_mode;
  logic [9:0]                 hdr_topleft_x;
  logic [9:0]                 hdr_topleft_y;
  logic [1:0]                 hdr_t1_cnt;
  logic [2:0]                 hdr_t1_flag;
  logic [CW-1:0]              hdr_total_coeff;
  logic [CW-1:0]              hdr_total_zero;
  logic [CW-1:0]              hdr_level_cnt;
  logic [CW-1:0]              hdr_run_cnt;

  logic                       elem_valid;
  logic [CW-1:0]              elem_idx;
  logic [LVL_W-1:0]           elem_level;
  logic                       elem_level_vld;
  logic [RB_W-1:0]            elem_run;
  logic                       elem_run_vld;
  logic                       elem_last;

  logic                       out_valid;
  logic                       out_ready;
  logic                       cnt_err;

  modport master (
    output in_valid, in_nc_mode, in_topleft_x, in_topleft_y, in_t1_cnt, in_t1_flag,
           in_total_coeff, in_total_zero, in_level_cnt, in_run_cnt, in_level_list, in_run_list,
           out_ready,
    input  in_ready,
           hdr_nc_mode, hdr_topleft_x, hdr_topleft_y, hdr_t1_cnt, hdr_t1_flag,
           hdr_total_coeff, hdr_total_zero, hdr_level_cnt, hdr_run_cnt,
           elem_valid, elem_idx, elem_level, elem_level_vld, elem_run, elem_run_vld, elem_last,
           out_valid, cnt_err
  );

  modport slave (
    input  in_valid, in_nc_mode, in_topleft_x, in_topleft_y, in_t1_cnt, in_t1_flag,
           in_total_coeff, in_total_zero, in_level_cnt, in_run_cnt, in_level_list, in_run_list,
           out_ready,
    output in_ready,
           hdr_nc_mode, hdr_topleft_x, hdr_topleft_y, hdr_t1_cnt, hdr_t1_flag,
           hdr_total_coeff, hdr_total_zero, hdr_level_cnt, hdr_run_cnt,
           elem_valid, elem_idx, elem_level, elem_level_vld, elem_run, elem_run_vld, elem_last,
           out_valid, cnt_err
  );
endinterface

// File: rtl/cavlc_enc_seq.sv
// CAVLC encoder sequencer.
// Buffers up to two block descriptors in a small FIFO, loads one at a time
// into the active registers, streams its level/run entries one element per
// cycle, then holds the block (out_valid) until the bitstream stage accepts it.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - cavlc_enc_seq_if.slave: descriptor input, header/element outputs,
//          output handshake and sticky cnt_err
module cavlc_enc_seq #(
  parameter int MAX_COEFF = 16,
  parameter int LVL_W     = 8,
  parameter int RB_W      = 5,
  parameter int CW        = 5
) (
  input logic            clk,
  input logic            rst,
  cavlc_enc_seq_if.slave bus
);

  typedef struct packed {
    logic [1:0]                       nc_mode;
    logic [9:0]                       x;
    logic [9:0]                       y;
    logic [1:0]                       t1_cnt;
    logic [2:0]                       t1_flag;
    logic [CW-1:0]                    total_coeff;
    logic [CW-1:0]                    total_zero;
    logic [CW-1:0]                    level_cnt;
    logic [CW-1:0]                    run_cnt;
    logic [MAX_COEFF-1:0][LVL_W-1:0]  level_list;
    logic [MAX_COEFF-1:0][RB_W-1:0]   run_list;
  } desc_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ENC, S_WAITBIS} state_t;

  function automatic logic [CW-1:0] clip_cnt(input logic [CW-1:0] c, input logic [CW-1:0] lim);
    return (c > lim) ? lim : c;
  endfunction

  function automatic logic [CW-1:0] max_cnt(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t        state, state_nxt;
  desc_t         push_d, head, act;
  desc_t         fifo_mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    fifo_cnt;
  logic          full, empty, push, pop;
  logic          chroma, clip_hit, cnt_err;
  logic [CW-1:0] lim, head_n, act_n, idx;
  logic          enc, load_en, wait_bis, idx_last;
  logic [LVL_W-1:0] lvl_sel;
  logic [RB_W-1:0]  run_sel;

  // Push side: clip counts and, for chroma DC, drop entries beyond index 3
  always_comb begin
    chroma   = (bus.in_nc_mode == 2'd1);
    lim      = chroma ? CW'(4) : CW'(MAX_COEFF);
    clip_hit = (bus.in_total_coeff > lim) || (bus.in_total_zero > lim) ||
               (bus.in_level_cnt > lim) || (bus.in_run_cnt > lim);
    push_d.nc_mode     = bus.in_nc_mode;
    push_d.x           = bus.in_topleft_x;
    push_d.y           = bus.in_topleft_y;
    push_d.t1_cnt      = bus.in_t1_cnt;
    push_d.t1_flag     = bus.in_t1_flag;
    push_d.total_coeff = clip_cnt(bus.in_total_coeff, lim);
    push_d.total_zero  = clip_cnt(bus.in_total_zero, lim);
    push_d.level_cnt   = clip_cnt(bus.in_level_cnt, lim);
    push_d.run_cnt     = clip_cnt(bus.in_run_cnt, lim);
    for (int i = 0; i < MAX_COEFF; i++) begin
      push_d.level_list[i] = (chroma && i >= 4) ? '0 : bus.in_level_list[i*LVL_W +: LVL_W];
      push_d.run_list[i]   = (chroma && i >= 4) ? '0 : bus.in_run_list[i*RB_W +: RB_W];
    end
  end

  assign full   = (fifo_cnt == 2'd2);
  assign empty  = (fifo_cnt == 2'd0);
  assign push   = bus.in_valid && bus.in_ready;
  assign pop    = load_en;
  assign head   = fifo_mem[rd_ptr];
  assign head_n = max_cnt(head.level_cnt, head.run_cnt);

  // FIFO control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      cnt_err  <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push && clip_hit) cnt_err <= 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_d;
  end

  // Active block registers; cleared on reset so every output reads 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act   <= '0;
      act_n <= '0;
      idx   <= '0;
    end else if (load_en) begin
      act   <= head;
      act_n <= head_n;
      idx   <= '0;
    end else if (enc) begin
      idx   <= idx + CW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  assign idx_last = (idx == act_n - CW'(1));

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (!empty) state_nxt = S_LOAD;
      S_LOAD:    state_nxt = (head_n != '0) ? S_ENC : S_WAITBIS;
      S_ENC:     if (idx_last) state_nxt = S_WAITBIS;
      S_WAITBIS: if (bus.out_ready) state_nxt = empty ? S_IDLE : S_LOAD;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    load_en  = (state == S_LOAD);
    enc      = (state == S_ENC);
    wait_bis = (state == S_WAITBIS);
  end

  always_comb begin
    lvl_sel = '0;
    run_sel = '0;
    for (int i = 0; i < MAX_COEFF; i++) begin
      if (CW'(i) == idx) begin
        lvl_sel = act.level_list[i];
        run_sel = act.run_list[i];
      end
    end
  end

  assign bus.in_ready       = !full && !rst;
  assign bus.out_valid      = wait_bis;
  assign bus.cnt_err        = cnt_err;
  assign bus.elem_valid     = enc;
  assign bus.elem_idx       = enc ? idx : '0;
  assign bus.elem_last      = enc && idx_last;
  assign bus.elem_level_vld = enc && (idx < act.level_cnt);
  assign bus.elem_run_vld   = enc && (idx < act.run_cnt);
  assign bus.elem_level     = bus.elem_level_vld ? lvl_sel : '0;
  assign bus.elem_run       = enc ? run_sel : '0;

  // During LOAD the head is shown directly so the header is stable from LOAD onward
  assign bus.hdr_nc_mode     = load_en ? head.nc_mode     : act.nc_mode;
  assign bus.hdr_topleft_x   = load_en ? head.x           : act.x;
  assign bus.hdr_topleft_y   = load_en ? head.y           : act.y;
  assign bus.hdr_t1_cnt      = load_en ? head.t1_cnt      : act.t1_cnt;
  assign bus.hdr_t1_flag     = load_en ? head.t1_flag     : act.t1_flag;
  assign bus.hdr_total_coeff = load_en ? head.total_coeff : act.total_coeff;
  assign bus.hdr_total_zero  = load_en ? head.total_zero  : act.total_zero;
  assign bus.hdr_level_cnt   = load_en ? head.level_cnt   : act.level_cnt;
  assign bus.hdr_run_cnt     = load_en ? head.run_cnt     : act.run_cnt;

endmodule

// File: tb/tb_cavlc_enc_seq.sv
// Directed testbench for cavlc_enc_seq (default parameters: 16/8/5/5).
module tb_cavlc_enc_seq;
  logic clk;
  logic rst;

  cavlc_enc_seq_if bus ();

  cavlc_enc_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_lvl [16];
  logic [4:0] exp_run [16];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] mode, input logic [9:0] x, input logic [9:0] y,
                      input logic [4:0] tc, input logic [4:0] tz,
                      input logic [4:0] lc, input logic [4:0] rc);
    int w;
    bus.in_nc_mode     = mode;
    bus.in_topleft_x   = x;
    bus.in_topleft_y   = y;
    bus.in_t1_cnt      = 2'd1;
    bus.in_t1_flag     = 3'b101;
    bus.in_total_coeff = tc;
    bus.in_total_zero  = tz;
    bus.in_level_cnt   = lc;
    bus.in_run_cnt     = rc;
    for (int i = 0; i < 16; i++) begin
      bus.in_level_list[i*8 +: 8] = exp_lvl[i];
      bus.in_run_list[i*5 +: 5]   = exp_run[i];
    end
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 50) chk("push_wait", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Called right after the push edge with out_ready=1; n, lc, rc are the
  // hand-derived element count and clipped level/run counts.
  task automatic watch(input string tag, input int n, input int lc, input int rc);
    int i;
    for (int k = 1; k <= n + 3; k++) begin
      @(posedge clk); #1;
      chk({tag, "_ev"}, bus.elem_valid, (k >= 2 && k < n + 2));
      chk({tag, "_ov"}, bus.out_valid, (k == n + 2));
      if (k == 1) chk({tag, "_hdr_lc"}, bus.hdr_level_cnt, lc);
      if (k >= 2 && k < n + 2) begin
        i = k - 2;
        chk({tag, "_idx"}, bus.elem_idx, i);
        chk({tag, "_last"}, bus.elem_last, (i == n - 1));
        chk({tag, "_lvld"}, bus.elem_level_vld, (i < lc));
        chk({tag, "_lvl"}, bus.elem_level, (i < lc) ? exp_lvl[i] : 8'd0);
        chk({tag, "_rvld"}, bus.elem_run_vld, (i < rc));
        if (i < rc) chk({tag, "_run"}, bus.elem_run, exp_run[i]);
      end
    end
  endtask

  task automatic set_a();
    for (int i = 0; i < 16; i++) begin
      exp_lvl[i] = 8'd0;
      exp_run[i] = 5'd0;
    end
    exp_lvl[0] = 8'd5; exp_lvl[1] = 8'hFD; exp_lvl[2] = 8'd1;
    exp_run[0] = 5'd2; exp_run[1] = 5'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] x_e [3];
    logic [4:0] tc_e [3];
    int ord;
    int cyc;
    bit seen;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_nc_mode = '0; bus.in_topleft_x = '0; bus.in_topleft_y = '0;
    bus.in_t1_cnt = '0; bus.in_t1_flag = '0; bus.in_total_coeff = '0; bus.in_total_zero = '0;
    bus.in_level_cnt = '0; bus.in_run_cnt = '0; bus.in_level_list = '0; bus.in_run_list = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_elem_valid", bus.elem_valid, 1'b0);
    chk("rst_cnt_err", bus.cnt_err, 1'b0);
    chk("rst_hdr_x", bus.hdr_topleft_x, 10'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_in_ready", bus.in_ready, 1'b1);

    // Basic block: 3 levels, 2 runs
    set_a();
    push(2'd0, 10'd10, 10'd20, 5'd3, 5'd3, 5'd3, 5'd2);
    watch("a", 3, 3, 2);
    chk("a_cnt_err", bus.cnt_err, 1'b0);

    // Empty block
    for (int i = 0; i < 16; i++) begin exp_lvl[i] = 8'd0; exp_run[i] = 5'd0; end
    push(2'd0, 10'd1, 10'd2, 5'd0, 5'd0, 5'd0, 5'd0);
    watch("z", 0, 0, 0);

    // Three blocks with the bitstream stage stalled
    bus.out_ready = 1'b0;
    x_e[0] = 10'd100; x_e[1] = 10'd200; x_e[2] = 10'd300;
    tc_e[0] = 5'd2; tc_e[1] = 5'd1; tc_e[2] = 5'd0;
    push(2'd2, x_e[0], 10'd7, tc_e[0], 5'd0, 5'd2, 5'd1);
    push(2'd2, x_e[1], 10'd7, tc_e[1], 5'd0, 5'd1, 5'd0);
    push(2'd2, x_e[2], 10'd7, tc_e[2], 5'd0, 5'd0, 5'd0);
    chk("full_in_ready", bus.in_ready, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("stall_in_ready", bus.in_ready, 1'b0);
    chk("stall_out_valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    ord = 0;
    cyc = 0;
    while (ord < 3 && cyc < 100) begin
      if (bus.out_valid) begin
        chk("order_x", bus.hdr_topleft_x, x_e[ord]);
        chk("order_tc", bus.hdr_total_coeff, tc_e[ord]);
        ord++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("order_count", ord, 3);

    // Level count above MAX_COEFF is clipped to 16
    for (int i = 0; i < 16; i++) begin exp_lvl[i] = 8'(i + 1); exp_run[i] = 5'd0; end
    push(2'd0, 10'd30, 10'd40, 5'd16, 5'd0, 5'd20, 5'd0);
    watch("clip", 16, 16, 0);
    chk("clip_cnt_err", bus.cnt_err, 1'b1);

    // Chroma DC: only 4 elements, run count clipped to 4
    for (int i = 0; i < 16; i++) begin exp_lvl[i] = 8'(8'h10 + i); exp_run[i] = 5'(i + 1); end
    push(2'd1, 10'd50, 10'd60, 5'd4, 5'd0, 5'd4, 5'd7);
    watch("cdc", 4, 4, 4);
    chk("cdc_cnt_err_sticky", bus.cnt_err, 1'b1);

    // Reset during ENC cycle 5 of 16 with a second block buffered
    for (int i = 0; i < 16; i++) begin exp_lvl[i] = 8'(i + 1); exp_run[i] = 5'd1; end
    push(2'd0, 10'd70, 10'd80, 5'd16, 5'd0, 5'd16, 5'd16);
    push(2'd0, 10'd90, 10'd90, 5'd2, 5'd0, 5'd2, 5'd2);
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_idx", bus.elem_idx, 5'd4);
    rst = 1'b1;
    #1;
    chk("mid_rst_ev", bus.elem_valid, 1'b0);
    chk("mid_rst_ov", bus.out_valid, 1'b0);
    chk("mid_rst_idx", bus.elem_idx, 5'd0);
    chk("mid_rst_lvl", bus.elem_level, 8'd0);
    chk("mid_rst_hdr_lc", bus.hdr_level_cnt, 5'd0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b0);
    chk("mid_rst_cnt_err", bus.cnt_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.elem_valid || bus.out_valid) seen = 1'b1;
    end
    chk("rst_discard", seen, 1'b0);
    chk("post_rst_in_ready", bus.in_ready, 1'b1);

    // Fresh block after reset
    set_a();
    push(2'd0, 10'd11, 10'd22, 5'd3, 5'd3, 5'd3, 5'd2);
    watch("fresh", 3, 3, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cavlc_enc_seq.md
CAVLC_ENC_SEQ -- requirements
Module: cavlc_enc_seq

Interface
REQ-001 Parameter MAX_COEFF, default 16, sets the maximum coefficients per block; legal values are 4 (chroma DC), 15 (AC) and 16 (luma 4x4).
REQ-002 Parameter LVL_W, default 8, sets the width of one level_code entry.
REQ-003 Parameter RB_W, default 5, sets the width of one run_before entry.
REQ-004 Parameter CW, default 5, sets the width of every count field; it must hold MAX_COEFF.
REQ-005 clk  in  1  single clock; all logic is rising-edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 in_valid  in  1  an input block descriptor is present.
REQ-008 in_ready  out  1  the input buffer can accept a descriptor.
REQ-009 in_nc_mode  in  2  0 = nC from neighbours, 1 = chroma DC (nC=-1), 2 = AC.
REQ-010 in_topleft_x, in_topleft_y  in  10 each  block position.
REQ-011 in_t1_cnt  in  2  trailing-ones count.
REQ-012 in_t1_flag  in  3  trailing-ones sign bits.
REQ-013 in_total_coeff, in_total_zero, in_level_cnt, in_run_cnt  in  CW each  block counts.
REQ-014 in_level_list  in  MAX_COEFF*LVL_W  packed list; entry i occupies bits [i*LVL_W +: LVL_W].
REQ-015 in_run_list  in  MAX_COEFF*RB_W  packed list, same packing as in_level_list.
REQ-016 hdr_* outputs  out  (same widths as the in_* fields)  header fields of the active block, held for its whole lifetime.
REQ-017 elem_valid  out  1  one element per cycle during ENC.
REQ-018 elem_idx  out  CW  index of the current element.
REQ-019 elem_level  out  LVL_W  level entry at elem_idx, or 0 when elem_idx >= level_cnt.
REQ-020 elem_level_vld  out  1  the elem_level entry is valid.
REQ-021 elem_run  out  RB_W  run entry at elem_idx.
REQ-022 elem_run_vld  out  1  the elem_run entry is valid.
REQ-023 elem_last  out  1  marks the final element of the block.
REQ-024 out_valid  out  1  the block is encoded and waiting for the bitstream stage.
REQ-025 out_ready  in  1  the bitstream stage accepts the block.
REQ-026 cnt_err  out  1  sticky flag: a count was clipped.

Function
REQ-027 The input buffer shall be a 2-entry FIFO of descriptors, with in_ready = !full.
REQ-028 A push shall occur when in_valid && in_ready.
REQ-029 The FSM shall have the states IDLE, LOAD, ENC and WAITBIS.
REQ-030 IDLE shall move to LOAD when the FIFO is non-empty.
REQ-031 LOAD shall copy the FIFO head into the active registers and pop the FIFO in the same cycle.
REQ-032 LOAD shall compute N = max(level_cnt, run_cnt) after clipping.
REQ-033 LOAD shall move to ENC if N > 0, otherwise directly to WAITBIS.
REQ-034 In ENC, elem_valid=1 and elem_idx shall count 0..N-1, one per cycle, with elem_last=1 at N-1; ENC shall then move to WAITBIS.
REQ-035 ENC shall take exactly N cycles; total latency from push into an empty idle block to out_valid shall be N+2 cycles (N=0 gives 2).
REQ-036 In WAITBIS, out_valid=1; on out_ready the FSM shall move to IDLE, or to LOAD if the FIFO is non-empty in that cycle (back-to-back).
REQ-037 hdr_* outputs shall stay stable from LOAD until the out_valid&&out_ready handshake.
REQ-038 Any count above MAX_COEFF shall be clipped to MAX_COEFF at push, and cnt_err shall be set; cnt_err clears only on reset.
REQ-039 In chroma DC mode (in_nc_mode=1), entries at index >= 4 shall be ignored and counts clipped to 4, even when MAX_COEFF > 4.
REQ-040 A push and a pop in the same cycle shall be legal: FIFO occupancy is unchanged and no data is lost.
REQ-041 A push while full shall be impossible (in_ready=0); in_valid while full shall be ignored.
REQ-042 The FIFO read and write pointers shall be 1 bit each and wrap modulo 2.

Reset
REQ-043 While rst=1, the state shall be IDLE, the FIFO empty and counters 0.
REQ-044 While rst=1, every output shall be 0, except in_ready=0 during reset and 1 from the first cycle after release.
REQ-045 Reset asserted mid-ENC or mid-WAITBIS shall discard the active block and buffered blocks with no further elem_valid or out_valid.

Verification
REQ-046 Push level_cnt=3, run_cnt=2 -> elem_valid for 3 cycles, idx 0,1,2; run_vld=1,1,0; elem_last at idx 2; out_valid 5 cycles after push.
REQ-047 Push total_coeff=0, all counts 0 -> no elem_valid; out_valid 2 cycles after push.
REQ-048 Push 3 blocks with out_ready=0 -> in_ready drops after 2 buffered plus 1 active; with out_ready=1, blocks exit in order and hdr fields match each push.
REQ-049 in_level_cnt=20 with MAX_COEFF=16 -> N=16, cnt_err=1 until reset.
REQ-050 Mode 1, level_cnt=4, MAX_COEFF=16 -> 4 elements only.
REQ-051 Assert rst during ENC cycle 5 of 16 -> all outputs 0 immediately; after release, a fresh push encodes normally.
